pipelined_addsub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor.
- Successor to the fixed 8-bit ripple adder; generalised to WIDTH bits.
- Carry is broken into STAGE_W-bit slices, with one register stage per slice, so throughput is one operation per clock.
- Valid/ready handshake on both sides with full backpressure; sits between operand producers and result consumers in the datapath.

---
 rtl/pipelined_addsub.sv | 146 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined two's-complement adder/subtractor with valid/ready handshake
//
// Carry chain is cut into STAGE_W-bit slices, one register stage per slice,
// STAGES = ceil(WIDTH/STAGE_W) cycles of latency, one operation per clock.
// Optional build macro ADDSUB_SAT_EN: signed saturation of sum on overflow.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin, sub)
//   a, b                  WIDTH-bit operands
//   cin                   carry-in for add (ignored when sub=1)
//   sub                   0: a+b+cin, 1: a-b
//   out_valid / out_ready result handshake (sum, cout, ovf)
//   sum                   WIDTH-bit result
//   cout                  carry out of MSB (for sub, 1 = no borrow)
//   ovf                   signed overflow
module pipelined_addsub #(
    parameter int WIDTH   = 8,
    parameter int STAGE_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = (WIDTH + STAGE_W - 1) / STAGE_W;
    localparam int LAST   = STAGES - 1;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;     // carry out of this slice
        logic             cmsb;  // carry into bit WIDTH-1 (only set by the slice owning the MSB)
    } slice_res_t;

    // Ripple-add only the bits belonging to slice k; other sum bits pass through.
    function automatic slice_res_t add_slice(input int k,
                                             input logic [WIDTH-1:0] op_a,
                                             input logic [WIDTH-1:0] op_b,
                                             input logic [WIDTH-1:0] s_in,
                                             input logic c_in);
        slice_res_t r;
        logic       c;
        r.s    = s_in;
        r.cmsb = 1'b0;
        c      = c_in;
        for (int i = 0; i < WIDTH; i++) begin
            if (i / STAGE_W == k) begin
                if (i == WIDTH - 1) r.cmsb = c;
                r.s[i] = op_a[i] ^ op_b[i] ^ c;
                c      = (op_a[i] & op_b[i]) | (op_a[i] & c) | (op_b[i] & c);
            end
        end
        r.c = c;
        return r;
    endfunction

    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] bp_q [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             v_q  [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d  [STAGES];
    logic [WIDTH-1:0] bp_d [STAGES];
    logic [WIDTH-1:0] s_d  [STAGES];
    logic             c_d  [STAGES];
    logic             v_d  [STAGES];
    logic             ovf_d;

    slice_res_t       res  [STAGES];
    logic             advance;

    // Whole pipe moves as one; a held result stalls every stage.
    assign advance  = !v_q[LAST] | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // b is inverted once at entry; the op's sub bit is not needed further down.
            assign a_d[k]  = a;
            assign bp_d[k] = sub ? ~b : b;
            assign v_d[k]  = in_valid;
            assign res[k]  = add_slice(k, a, sub ? ~b : b, '0, sub | cin);
        end else begin : g_next
            assign a_d[k]  = a_q[k-1];
            assign bp_d[k] = bp_q[k-1];
            assign v_d[k]  = v_q[k-1];
            assign res[k]  = add_slice(k, a_q[k-1], bp_q[k-1], s_q[k-1], c_q[k-1]);
        end

        assign c_d[k] = res[k].c;

        if (k == LAST) begin : g_final
            assign ovf_d = res[k].cmsb ^ res[k].c;
`ifdef ADDSUB_SAT_EN
            // Saturate toward the sign of A; cout/ovf keep the raw condition.
            assign s_d[k] = !ovf_d ? res[k].s :
                            a_d[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
`else
            assign s_d[k] = res[k].s;
`endif
        end else begin : g_mid
            assign s_d[k] = res[k].s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bp_q[k] <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                v_q[k]  <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                bp_q[k] <= bp_d[k];
                s_q[k]  <= s_d[k];
                c_q[k]  <= c_d[k];
                v_q[k]  <= v_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub
module tb_pipelined_addsub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0, sub = 1'b0;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout, ovf;

    logic        v13 = 1'b0, r13, ov13;
    logic [12:0] a13 = '0, b13 = '0, s13;
    logic        co13, of13;

    logic        v88 = 1'b0, r88, ov88;
    logic [7:0]  a88 = '0, b88 = '0, s88;
    logic        co88, of88;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(8), .STAGE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf));

    pipelined_addsub #(.WIDTH(13), .STAGE_W(4)) u13 (
        .clk(clk), .rst_n(rst_n), .in_valid(v13), .in_ready(r13),
        .a(a13), .b(b13), .cin(1'b0), .sub(1'b0),
        .out_valid(ov13), .out_ready(1'b1),
        .sum(s13), .cout(co13), .ovf(of13));

    pipelined_addsub #(.WIDTH(8), .STAGE_W(8)) u88 (
        .clk(clk), .rst_n(rst_n), .in_valid(v88), .in_ready(r88),
        .a(a88), .b(b88), .cin(1'b0), .sub(1'b0),
        .out_valid(ov88), .out_ready(1'b1),
        .sum(s88), .cout(co88), .ovf(of88));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands, signed overflow from sign rules.
    function automatic logic [9:0] model(input logic [7:0] oa, input logic [7:0] ob,
                                         input logic oc, input logic os);
        int          ua, ub, full;
        logic [7:0]  s;
        logic        co, ov;
        ua   = int'(oa);
        ub   = os ? (255 - int'(ob)) : int'(ob);
        full = ua + ub + (os ? 1 : int'(oc));
        s    = full[7:0];
        co   = (full >= 256);
        ov   = (oa[7] == ub[7]) && (s[7] != oa[7]);
`ifdef ADDSUB_SAT_EN
        if (ov) s = oa[7] ? 8'h80 : 8'h7F;
`endif
        return {ov, co, s};
    endfunction

    // Scoreboard / compare process.
    logic [9:0] exp_q[$];
    logic [9:0] prev_out;
    logic       prev_stall = 1'b0;
    int         retired = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid | out_ready)});
            if (prev_stall)
                chk("stall_hold", {21'd0, out_valid, ovf, cout, sum}, {21'd0, 1'b1, prev_out});
            prev_stall = out_valid && !out_ready;
            prev_out   = {ovf, cout, sum};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_result", {22'd0, ovf, cout, sum}, 32'hFFFF_FFFF);
                end else begin
                    chk("result", {22'd0, ovf, cout, sum}, {22'd0, exp_q.pop_front()});
                    retired++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic rand_op(input logic c_force, input logic use_force);
        a   = 8'($urandom);
        b   = 8'($urandom);
        sub = use_force ? 1'b0 : 1'($urandom);
        cin = use_force ? c_force : 1'($urandom);
    endtask

    task automatic one_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                          input logic os, output int lat);
        @(posedge clk); #1;
        a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int         lat, cnt, first, last;
        logic       took;
        logic [9:0] held;

        // Model pinned to hand-computed values.
        chk("model_add", {22'd0, model(8'hD9, 8'h6D, 1'b0, 1'b0)}, {22'd0, 2'b01, 8'h46});
        chk("model_sub", {22'd0, model(8'h05, 8'h07, 1'b0, 1'b1)}, {22'd0, 2'b00, 8'hFE});
`ifdef ADDSUB_SAT_EN
        chk("model_ovf", {22'd0, model(8'h80, 8'h01, 1'b0, 1'b1)}, {22'd0, 2'b11, 8'h80});
`else
        chk("model_ovf", {22'd0, model(8'h80, 8'h01, 1'b0, 1'b1)}, {22'd0, 2'b11, 8'h7F});
`endif

        // Reset state.
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outputs", {22'd0, ovf, cout, sum}, 32'd0);
        chk("rst_in_ready13", {31'd0, r13}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed ops, latency and literal results.
        one_op(8'hD9, 8'h6D, 1'b0, 1'b0, lat);
        chk("lat_add", lat, 4);
        chk("dir_add", {22'd0, ovf, cout, sum}, {22'd0, 2'b01, 8'h46});
        one_op(8'h05, 8'h07, 1'b0, 1'b1, lat);
        chk("dir_sub_borrow", {22'd0, ovf, cout, sum}, {22'd0, 2'b00, 8'hFE});
        one_op(8'h80, 8'h01, 1'b0, 1'b1, lat);
`ifdef ADDSUB_SAT_EN
        chk("dir_sub_ovf", {22'd0, ovf, cout, sum}, {22'd0, 2'b11, 8'h80});
`else
        chk("dir_sub_ovf", {22'd0, ovf, cout, sum}, {22'd0, 2'b11, 8'h7F});
`endif

        // 16 back-to-back adds, cin=1 on odd ops.
        @(posedge clk); #1;
        cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0 && out_valid) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            if (c < 16) begin
                chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
                rand_op(1'(c % 2), 1'b1);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("stream_count", cnt, 16);
        chk("stream_first", first, 4);
        chk("stream_contig", last - first, 15);

        // Backpressure: fill with out_ready=0, hold 5 cycles, then drain.
        out_ready = 1'b0;
        rand_op(1'b0, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) rand_op(1'b0, 1'b0);
        end
        held = {ovf, cout, sum};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_held", {22'd0, ovf, cout, sum}, {22'd0, held});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_drained", exp_q.size(), 0);

        // Asynchronous reset mid-stream.
        for (int c = 0; c < 5; c++) begin
            rand_op(1'b0, 1'b0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("no_stale", cnt, 0);

        // Mixed random traffic with random backpressure.
        in_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took || !in_valid) begin
                rand_op(1'b0, 1'b0);
                in_valid = 1'($urandom_range(0, 3) != 0);
            end
            out_ready = 1'($urandom_range(0, 2) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("final_drained", exp_q.size(), 0);
        if (retired < 60) chk("retired_enough", retired, 60);

        // WIDTH=13, STAGE_W=4: 1-bit last slice.
        @(posedge clk); #1;
        a13 = 13'h1FFF; b13 = 13'h0001; v13 = 1'b1;
        @(posedge clk); #1;
        v13 = 1'b0; lat = 1;
        while (!ov13 && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("w13_lat", lat, 4);
        chk("w13_wrap", {17'd0, of13, co13, s13}, {17'd0, 2'b01, 13'h0000});
        @(posedge clk); #1;
        a13 = 13'h0FFF; b13 = 13'h0001; v13 = 1'b1;
        @(posedge clk); #1;
        v13 = 1'b0; lat = 1;
        while (!ov13 && lat < 20) begin @(posedge clk); #1; lat++; end
`ifdef ADDSUB_SAT_EN
        chk("w13_ovf", {17'd0, of13, co13, s13}, {17'd0, 2'b10, 13'h0FFF});
`else
        chk("w13_ovf", {17'd0, of13, co13, s13}, {17'd0, 2'b10, 13'h1000});
`endif

        // STAGE_W >= WIDTH: single stage, latency 1.
        @(posedge clk); #1;
        a88 = 8'h7F; b88 = 8'h01; v88 = 1'b1;
        @(posedge clk); #1;
        v88 = 1'b0; lat = 1;
        while (!ov88 && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("w88_lat", lat, 1);
`ifdef ADDSUB_SAT_EN
        chk("w88_ovf", {22'd0, of88, co88, s88}, {22'd0, 2'b10, 8'h7F});
`else
        chk("w88_ovf", {22'd0, of88, co88, s88}, {22'd0, 2'b10, 8'h80});
`endif
        chk("w88_ready", {31'd0, r88}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
